// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Control sequencer for the bit-sliced PC/LR datapath. Takes one-word
//   commands from the main control FSM plus a level interrupt request and
//   produces the per-cycle select, write-enable, bus-drive and carry-in
//   controls for the PC and LR slices. Handles increment, jump, call,
//   return, PC read-out, LR load and interrupt entry/exit. PC and LR are
//   never allowed to drive SysBus in the same cycle, and a turnaround
//   cycle follows every command that leaves a driver on the bus.
//
// Ports:
//   Clock     in   1  system clock, all state changes on the rising edge
//   Reset     in   1  synchronous active-high reset
//   CmdValid  in   1  a command is present on Cmd
//   Cmd       in   3  0 NOP, 1 INC, 2 JMP, 3 CALL, 4 RET, 5 RDPC, 6 LDLR, 7 RETI
//   CmdReady  out  1  a command can be accepted this cycle
//   Done      out  1  pulse in the final execute cycle of a command or irq entry
//   Stall     in   1  freeze sequencing this cycle
//   IrqReq    in   1  level-sensitive interrupt request
//   IrqAck    out  1  vector-fetch cycle, requester drives vector onto SysBus
//   Ie        out  1  interrupt-enable flag
//   PcSel     out  2  PC next-value select (0 inc, 1 SysBus, 2 ALU out)
//   PcWe      out  1  PC write enable
//   PcEn      out  1  PC tristate drive onto SysBus
//   PcIncCin  out  1  carry-in of the PC incrementer
//   LrSel     out  1  LR next-value select (0 PC path, 1 SysBus)
//   LrWe      out  1  LR write enable
//   LrEn      out  1  LR tristate drive onto SysBus
// ---------------------------------------------------------------------------
module pc_sequencer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CmdValid,
    input  logic [2:0] Cmd,
    output logic       CmdReady,
    output logic       Done,
    input  logic       Stall,
    input  logic       IrqReq,
    output logic       IrqAck,
    output logic       Ie,
    output logic [1:0] PcSel,
    output logic       PcWe,
    output logic       PcEn,
    output logic       PcIncCin,
    output logic       LrSel,
    output logic       LrWe,
    output logic       LrEn
);

    // Datapath select encodings shared with the PC/LR slices.
    localparam logic [1:0] PcSelInc    = 2'd0;
    localparam logic [1:0] PcSelSysbus = 2'd1;
    localparam logic [1:0] PcSelAluOut = 2'd2;
    localparam logic       LrSelPc     = 1'b0;
    localparam logic       LrSelSys    = 1'b1;

    typedef enum logic [2:0] {
        CmdNop  = 3'd0,
        CmdInc  = 3'd1,
        CmdJmp  = 3'd2,
        CmdCall = 3'd3,
        CmdRet  = 3'd4,
        CmdRdpc = 3'd5,
        CmdLdlr = 3'd6,
        CmdReti = 3'd7
    } cmdCode_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StExec1 = 3'd1,
        StExec2 = 3'd2,
        StTurn  = 3'd3,
        StIrq1  = 3'd4,
        StIrq2  = 3'd5
    } seqState_t;

    seqState_t state;
    seqState_t nextState;
    cmdCode_t  curCmd;
    cmdCode_t  nextCmd;
    logic      ieFlag;
    logic      nextIe;

    logic      irqPending;
    logic      readyInt;
    logic      pcWeRaw;
    logic      lrWeRaw;
    logic      doneRaw;
    logic      irqAckRaw;

    // An enabled interrupt blocks command acceptance so it always wins a
    // tie with a simultaneous CmdValid in the idle state.
    assign irqPending = IrqReq & ieFlag;
    assign readyInt   = (state == StIdle) & ~irqPending & ~Stall;
    assign CmdReady   = readyInt;
    assign Ie         = ieFlag;

    // State, latched command and interrupt-enable register. A stalled
    // cycle leaves everything untouched so the same state re-executes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= StIdle;
            curCmd <= CmdNop;
            ieFlag <= 1'b0;
        end else begin
            state  <= nextState;
            curCmd <= nextCmd;
            ieFlag <= nextIe;
        end
    end

    // Next-state logic. RETI raises Ie on the accepting edge so the flag is
    // already visible during its execute cycle; interrupt entry clears Ie
    // when IRQ1 completes, so nesting is impossible until a RETI returns.
    always_comb begin
        nextState = state;
        nextCmd   = curCmd;
        nextIe    = ieFlag;
        if (!Stall) begin
            case (state)
                StIdle: begin
                    if (irqPending) begin
                        nextState = StIrq1;
                    end else if (CmdValid && readyInt) begin
                        nextState = StExec1;
                        nextCmd   = cmdCode_t'(Cmd);
                        if (cmdCode_t'(Cmd) == CmdReti) begin
                            nextIe = 1'b1;
                        end
                    end
                end
                StExec1: begin
                    case (curCmd)
                        CmdCall:                   nextState = StExec2;
                        CmdRet, CmdReti, CmdRdpc:  nextState = StTurn;
                        default:                   nextState = StIdle;
                    endcase
                end
                StExec2: nextState = StIdle;
                StTurn:  nextState = StIdle;
                StIrq1: begin
                    nextState = StIrq2;
                    nextIe    = 1'b0;
                end
                StIrq2:  nextState = StIdle;
                default: nextState = StIdle;
            endcase
        end
    end

    // Moore output decode from the registered state and latched command.
    // Everything defaults to the idle value: no enables, PC path selects.
    always_comb begin
        PcSel     = PcSelInc;
        PcEn      = 1'b0;
        PcIncCin  = 1'b0;
        LrSel     = LrSelPc;
        LrEn      = 1'b0;
        pcWeRaw   = 1'b0;
        lrWeRaw   = 1'b0;
        doneRaw   = 1'b0;
        irqAckRaw = 1'b0;
        case (state)
            StExec1: begin
                case (curCmd)
                    CmdNop: begin
                        doneRaw = 1'b1;
                    end
                    CmdInc: begin
                        PcSel    = PcSelInc;
                        PcIncCin = 1'b1;
                        pcWeRaw  = 1'b1;
                        doneRaw  = 1'b1;
                    end
                    CmdJmp: begin
                        PcSel   = PcSelAluOut;
                        pcWeRaw = 1'b1;
                        doneRaw = 1'b1;
                    end
                    CmdCall: begin
                        // Link register captures PC+1 through the incrementer.
                        LrSel    = LrSelPc;
                        PcIncCin = 1'b1;
                        lrWeRaw  = 1'b1;
                    end
                    CmdRet, CmdReti: begin
                        // LR drives the bus and PC loads it in the same cycle.
                        LrEn    = 1'b1;
                        PcSel   = PcSelSysbus;
                        pcWeRaw = 1'b1;
                        doneRaw = 1'b1;
                    end
                    CmdRdpc: begin
                        PcEn    = 1'b1;
                        doneRaw = 1'b1;
                    end
                    CmdLdlr: begin
                        LrSel   = LrSelSys;
                        lrWeRaw = 1'b1;
                        doneRaw = 1'b1;
                    end
                    default: begin
                        doneRaw = 1'b0;
                    end
                endcase
            end
            StExec2: begin
                // Only CALL has a second execute cycle: jump to the target.
                PcSel   = PcSelAluOut;
                pcWeRaw = 1'b1;
                doneRaw = 1'b1;
            end
            StIrq1: begin
                // Save the current PC unmodified as the return address.
                LrSel    = LrSelPc;
                PcIncCin = 1'b0;
                lrWeRaw  = 1'b1;
            end
            StIrq2: begin
                irqAckRaw = 1'b1;
                PcSel     = PcSelSysbus;
                pcWeRaw   = 1'b1;
                doneRaw   = 1'b1;
            end
            default: begin
                doneRaw = 1'b0;
            end
        endcase
    end

    // Stall suppresses every side effect of the cycle while the bus
    // drivers keep their state value, so the cycle replays cleanly.
    assign PcWe   = pcWeRaw   & ~Stall;
    assign LrWe   = lrWeRaw   & ~Stall;
    assign Done   = doneRaw   & ~Stall;
    assign IrqAck = irqAckRaw & ~Stall;

endmodule
